vga_timing_gen: RTL
===================

# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA path, clocked by the 25 MHz pixel clock. Produces the DrawX/DrawY/blank stream consumed by every sprite and screen renderer (game-over screen, playfield) and the hsync/vsync pins for the DAC/connector. Sync outputs carry a configurable delay so they line up with the renderers' registered RGB. Also emits a start-of-frame pulse and frame index for game logic.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DLY, 1, register stages on hs/vs relative to DrawX/DrawY/blank (legal 0..3)
- vga_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  out  10  current column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- blank  out  1  1 = visible region (DrawX<H_VISIBLE and DrawY<V_VISIBLE); renderers drive RGB only when 1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- frame_start  out  1  one-cycle pulse when position is (0,0)
- frame_num  out  8  index of current frame, wraps modulo 256

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter hc increments each clock; hc==H_TOTAL-1 -> hc=0 and vertical counter vc increments; vc==V_TOTAL-1 at that edge -> vc=0. Unsigned, no overflow past totals.
- DrawX = hc, DrawY = vc, both registers (no combinational path).
- blank, frame_start, and undelayed sync are registered, computed from next-state counters, so they are valid in the same cycle as the DrawX/DrawY they describe.
- hs_raw = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751); otherwise 1.
- vs_raw = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491), for whole lines; otherwise 1.
- hs/vs = hs_raw/vs_raw through SYNC_DLY-deep shift register; SYNC_DLY=0 -> no extra stage.
- frame_start = 1 exactly when (hc,vc)==(0,0); frame_num increments (mod 256) on the same edge.
- No idle/run state: free-running after reset release.

## Timing
- Reset (asynchronous, while reset_n=0): hc=H_TOTAL-1 (799), vc=V_TOTAL-1 (524); DrawX=799, DrawY=524, blank=0, frame_start=0, frame_num=8'hFF, hs=1, vs=1, all sync delay stages=1.
- First rising edge after reset_n rises: DrawX=0, DrawY=0, blank=1, frame_start=1, frame_num=0x00.
- Line period 800 clocks; frame period 420000 clocks.
- hs low for exactly 96 consecutive clocks per line, starting SYNC_DLY clocks after DrawX becomes 656.
- vs low for exactly 1600 consecutive clocks, starting SYNC_DLY clocks after (DrawX,DrawY) becomes (0,490).
- frame_num wrap 0xFF->0x00 behaves like any other increment.
- Reset asserted mid-frame: all outputs go to reset values immediately (no clock needed); sequence restarts as above on release, frame_num back to 0 on first edge.

## Test plan
- Reset: hold reset_n=0, toggle clock -> DrawX=799, DrawY=524, blank=0, hs=1, vs=1, frame_start=0, frame_num=0xFF; release -> next edge DrawX=0, DrawY=0, blank=1, frame_start=1, frame_num=0.
- Line scan, SYNC_DLY=1: blank=1 for DrawX 0..639 and 0 for 640..799 on line 0; hs=0 on exactly the cycles DrawX=657..752 (96 clocks), line wraps 799->0 with DrawY 0->1.
- Frame scan: blank=0 for all of DrawY 480..524; vs=0 from (DrawX,DrawY)=(1,490) through (0,492) with SYNC_DLY=1 (1600 clocks); (799,524)->(0,0) with frame_start=1 once per 420000 clocks.
- frame_num: run 256 frames (or force) -> 0xFF->0x00 wrap, frame_start pulse count equals frame_num advance.
- SYNC_DLY=0 and 3: hs falling edge coincides with DrawX=656 and DrawX=659 respectively; pulse widths unchanged.
- Reset mid-frame at (DrawX,DrawY)=(300,200): asynchronous return to reset values before next edge; after release, timing identical to first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA path: pixel/line counters, visible-region flag,
// sync pulses with configurable delay, and start-of-frame pulse with frame index.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned SYNC_DLY  = 1
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_start,
   output logic [7:0] frame_num
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST_C     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST_C     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_C      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_C      = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START_C   = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END_C     = 10'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START_C   = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END_C     = 10'(V_VISIBLE + V_FP + V_SYNC);

   logic [9:0] hc_r;
   logic [9:0] vc_r;
   logic [9:0] hc_nxt_s;
   logic [9:0] vc_nxt_s;
   logic       blank_r;
   logic       blank_nxt_s;
   logic       fs_r;
   logic       fs_nxt_s;
   logic [7:0] fn_r;
   logic       hs_raw_r;
   logic       vs_raw_r;
   logic       hs_raw_nxt_s;
   logic       vs_raw_nxt_s;

   // Next raster position: wrap the line at H_TOTAL, the frame at V_TOTAL
   always_comb begin
      hc_nxt_s = hc_r;
      vc_nxt_s = vc_r;
      if (hc_r == H_LAST_C) begin
         hc_nxt_s = 10'd0;
         if (vc_r == V_LAST_C) begin
            vc_nxt_s = 10'd0;
         end else begin
            vc_nxt_s = vc_r + 10'd1;
         end
      end else begin
         hc_nxt_s = hc_r + 10'd1;
      end
   end

   // Flags decoded from the next position so they register alongside the counters
   always_comb begin
      blank_nxt_s  = (hc_nxt_s < H_VIS_C) && (vc_nxt_s < V_VIS_C);
      fs_nxt_s     = (hc_nxt_s == 10'd0) && (vc_nxt_s == 10'd0);
      hs_raw_nxt_s = !((hc_nxt_s >= HS_START_C) && (hc_nxt_s < HS_END_C));
      vs_raw_nxt_s = !((vc_nxt_s >= VS_START_C) && (vc_nxt_s < VS_END_C));
   end

   // Counters and registered video/status flags; reset parks at the last position
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_r     <= H_LAST_C;
         vc_r     <= V_LAST_C;
         blank_r  <= 1'b0;
         fs_r     <= 1'b0;
         fn_r     <= 8'hFF;
         hs_raw_r <= 1'b1;
         vs_raw_r <= 1'b1;
      end else begin
         hc_r     <= hc_nxt_s;
         vc_r     <= vc_nxt_s;
         blank_r  <= blank_nxt_s;
         fs_r     <= fs_nxt_s;
         hs_raw_r <= hs_raw_nxt_s;
         vs_raw_r <= vs_raw_nxt_s;
         if (fs_nxt_s) begin
            fn_r <= fn_r + 8'd1;
         end else begin
            fn_r <= fn_r;
         end
      end
   end

   generate
      if (SYNC_DLY == 0) begin : g_no_dly
         assign hs = hs_raw_r;
         assign vs = vs_raw_r;
      end else begin : g_dly
         logic [SYNC_DLY-1:0] hs_dly_r;
         logic [SYNC_DLY-1:0] vs_dly_r;

         // Sync delay line, aligns hs/vs with downstream registered RGB
         always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
               hs_dly_r <= '1;
               vs_dly_r <= '1;
            end else begin
               hs_dly_r[0] <= hs_raw_r;
               vs_dly_r[0] <= vs_raw_r;
               for (int i = 1; i < int'(SYNC_DLY); i++) begin
                  hs_dly_r[i] <= hs_dly_r[i-1];
                  vs_dly_r[i] <= vs_dly_r[i-1];
               end
            end
         end

         assign hs = hs_dly_r[SYNC_DLY-1];
         assign vs = vs_dly_r[SYNC_DLY-1];
      end
   endgenerate

   assign DrawX       = hc_r;
   assign DrawY       = vc_r;
   assign blank       = blank_r;
   assign frame_start = fs_r;
   assign frame_num   = fn_r;

endmodule
